// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment controller: funct3 codes,
// FSM states and access-width decoding.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } lsu_state_e;

  // Access width in bytes; the unsigned variants share the low two bits.
  function automatic logic [2:0] f3_width(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
    if (is_store) return f3[2] || (f3[1:0] == 2'b11);
    else          return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/lsu_align_ctrl_if.sv
// Core-side request/response bus between the execute stage and the alignment
// controller. The core is the master, the controller the slave.
interface lsu_align_ctrl_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        fault;

  modport master (
    output req, we, funct3, addr, wdata,
    input  rdata, stall, fault
  );

  modport slave (
    input  req, we, funct3, addr, wdata,
    output rdata, stall, fault
  );
endinterface

// File: rtl/lsu_byte_lane.sv
// Combinational byte steering: load extract/extend from a 64-bit window
// (STORE=0) or byte-masked merge of a new word into an old one (STORE=1).
module lsu_byte_lane
  import lsu_pkg::*;
#(
  parameter bit STORE = 1'b0
) (
  input  logic [63:0] window,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  mask,
  output logic [31:0] result
);

  if (STORE) begin : g_merge
    always_comb begin
      for (int i = 0; i < 4; i++)
        result[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
  end else begin : g_extract
    logic [63:0] shifted;
    assign shifted = window >> {off, 3'b000};

    always_comb begin
      case (funct3)
        F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
        F3_BU:   result = {24'h0, shifted[7:0]};
        F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
        F3_HU:   result = {16'h0, shifted[15:0]};
        default: result = shifted[31:0];
      endcase
    end
  end

endmodule

// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller in front of a word-indexed data memory.
// Sub-word stores are read-modify-write; straddling accesses take two cycles.
module lsu_align_ctrl
  import lsu_pkg::*;
#(
  parameter int AW               = 10,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  lsu_align_ctrl_if.slave   bus,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  lsu_state_e  state, state_nxt;
  logic [31:0] lo_q;
  logic        lo_capture;

  logic [1:0]    off;
  logic [2:0]    width;
  logic [AW-1:0] word;
  logic          straddle;
  logic          fault_c;
  logic          in_second;

  assign off       = bus.addr[1:0];
  assign width     = f3_width(bus.funct3);
  assign word      = bus.addr[AW+1:2];
  assign straddle  = ({1'b0, off} + width) > 3'd4;
  assign in_second = (state == SECOND);

  // Checked only on entry; in SECOND the core holds the inputs already vetted.
  assign fault_c = bus.req && !in_second &&
                   (f3_illegal(bus.funct3, bus.we) ||
                    (|bus.addr[31:AW+2]) ||
                    (straddle && (!ALLOW_MISALIGNED || (&word))));
  assign bus.fault = rst && fault_c;

  // Store bytes laid out across the two-word span starting at the low word.
  logic [3:0]  width_mask;
  logic [7:0]  mask64;
  logic [63:0] data64;

  always_comb begin
    case (width)
      3'd1:    width_mask = 4'b0001;
      3'd2:    width_mask = 4'b0011;
      default: width_mask = 4'b1111;
    endcase
  end

  assign mask64 = {4'b0000, width_mask} << off;
  assign data64 = {32'h0, bus.wdata} << {off, 3'b000};

  logic [31:0] load_ext;

  lsu_byte_lane #(.STORE(1'b0)) u_load_lane (
    .window   (in_second ? {mem_rd, lo_q} : {32'h0, mem_rd}),
    .off      (off),
    .funct3   (bus.funct3),
    .old_word (32'h0),
    .new_word (32'h0),
    .mask     (4'b0000),
    .result   (load_ext)
  );

  lsu_byte_lane #(.STORE(1'b1)) u_store_lane (
    .window   (64'h0),
    .off      (2'b00),
    .funct3   (3'b000),
    .old_word (mem_rd),
    .new_word (in_second ? data64[63:32] : data64[31:0]),
    .mask     (in_second ? mask64[7:4]   : mask64[3:0]),
    .result   (mem_wd)
  );

  // NOTE: every output of this block gets a default first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    mem_addr   = word;
    mem_we     = 1'b0;
    bus.stall  = 1'b0;
    bus.rdata  = 32'h0;
    lo_capture = 1'b0;

    if (!rst) begin
      mem_addr = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req && !fault_c) begin
            mem_we = bus.we;
            if (straddle) begin
              bus.stall  = 1'b1;
              lo_capture = !bus.we;
              state_nxt  = SECOND;
            end else if (!bus.we) begin
              bus.rdata = load_ext;
            end
          end
        end
        SECOND: begin
          mem_addr  = word + AW'(1);
          state_nxt = IDLE;
          // A dropped req here is a pipeline flush: the high half is abandoned.
          if (bus.req) begin
            mem_we = bus.we;
            if (!bus.we) bus.rdata = load_ext;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      lo_q  <= 32'h0;
    end else begin
      state <= state_nxt;
      if (lo_capture) lo_q <= mem_rd;
    end
  end

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Directed bench for lsu_align_ctrl with a behavioural word memory attached.
module tb_lsu_align_ctrl;
  import lsu_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;
  logic [31:0]   mem [0:(1<<AW)-1];

  int tests = 0;
  int fails = 0;

  lsu_align_ctrl_if bus();

  lsu_align_ctrl #(.AW(AW), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = rst ? mem[mem_addr] : 32'h0;

  always @(posedge clk) if (rst && mem_we) mem[mem_addr] <= mem_wd;

  task automatic drive(input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    bus.req = r; bus.we = w; bus.funct3 = f3; bus.addr = a; bus.wdata = d;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, F3_W, 32'h10, 32'h1234_5678);
    #2;
    tests++; if (mem_we !== 1'b0) begin $display("FAIL reset_mem_we got=%b exp=0", mem_we); fails++; end
    tests++; if (bus.stall !== 1'b0) begin $display("FAIL reset_stall got=%b exp=0", bus.stall); fails++; end
    tests++; if (bus.fault !== 1'b0) begin $display("FAIL reset_fault got=%b exp=0", bus.fault); fails++; end
    tests++; if (bus.rdata !== 32'h0) begin $display("FAIL reset_rdata got=%h exp=0", bus.rdata); fails++; end
    tests++; if (mem_addr !== '0) begin $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); fails++; end
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_subword_load();
    mem[28] <= 32'hFFFF_FFFF;
    mem[6]  <= 32'h8001_7F80;
    drive(1'b1, 1'b0, F3_B, 32'h70, 32'h0);
    @(negedge clk);
    tests++; if (bus.rdata !== 32'hFFFF_FFFF) begin $display("FAIL lb_sign got=%h exp=ffffffff", bus.rdata); fails++; end
    tests++; if (bus.stall !== 1'b0) begin $display("FAIL lb_stall got=%b exp=0", bus.stall); fails++; end
    next_cycle();
    drive(1'b1, 1'b0, F3_BU, 32'h71, 32'h0);
    @(negedge clk);
    tests++; if (bus.rdata !== 32'h0000_00FF) begin $display("FAIL lbu_zero got=%h exp=000000ff", bus.rdata); fails++; end
    tests++; if (bus.stall !== 1'b0) begin $display("FAIL lbu_stall got=%b exp=0", bus.stall); fails++; end
    next_cycle();
    drive(1'b1, 1'b0, F3_B, 32'h18, 32'h0);
    @(negedge clk);
    tests++; if (bus.rdata !== 32'hFFFF_FF80) begin $display("FAIL lb_off0 got=%h exp=ffffff80", bus.rdata); fails++; end
    next_cycle();
    drive(1'b1, 1'b0, F3_HU, 32'h1A, 32'h0);
    @(negedge clk);
    tests++; if (bus.rdata !== 32'h0000_8001) begin $display("FAIL lhu_off2 got=%h exp=00008001", bus.rdata); fails++; end
    next_cycle();
    drive(1'b1, 1'b0, F3_H, 32'h1A, 32'h0);
    @(negedge clk);
    tests++; if (bus.rdata !== 32'hFFFF_8001) begin $display("FAIL lh_off2 got=%h exp=ffff8001", bus.rdata); fails++; end
    next_cycle();
  endtask

  task automatic test_byte_store();
    mem[5] <= 32'h1122_3344;
    drive(1'b1, 1'b1, F3_B, 32'h16, 32'h0000_00AB);
    @(negedge clk);
    tests++; if (mem_we !== 1'b1) begin $display("FAIL sb_we got=%b exp=1", mem_we); fails++; end
    tests++; if (mem_wd !== 32'h11AB_3344) begin $display("FAIL sb_wd got=%h exp=11ab3344", mem_wd); fails++; end
    next_cycle();
    drive(1'b1, 1'b0, F3_W, 32'h14, 32'h0);
    @(negedge clk);
    tests++; if (mem_we !== 1'b0) begin $display("FAIL sb_we_once got=%b exp=0", mem_we); fails++; end
    tests++; if (bus.rdata !== 32'h11AB_3344) begin $display("FAIL sb_readback got=%h exp=11ab3344", bus.rdata); fails++; end
    next_cycle();
  endtask

  task automatic test_straddle_load();
    mem[4] <= 32'h4433_2211;
    mem[5] <= 32'h8877_6655;
    drive(1'b1, 1'b0, F3_W, 32'h13, 32'h0);
    @(negedge clk);
    tests++; if (bus.stall !== 1'b1) begin $display("FAIL lw_split_stall1 got=%b exp=1", bus.stall); fails++; end
    tests++; if (mem_addr !== 10'd4) begin $display("FAIL lw_split_addr1 got=%0d exp=4", mem_addr); fails++; end
    next_cycle();
    @(negedge clk);
    tests++; if (bus.stall !== 1'b0) begin $display("FAIL lw_split_stall2 got=%b exp=0", bus.stall); fails++; end
    tests++; if (mem_addr !== 10'd5) begin $display("FAIL lw_split_addr2 got=%0d exp=5", mem_addr); fails++; end
    tests++; if (bus.rdata !== 32'h7766_5544) begin $display("FAIL lw_split_rdata got=%h exp=77665544", bus.rdata); fails++; end
    next_cycle();
    drive(1'b1, 1'b0, F3_H, 32'h13, 32'h0);
    @(negedge clk);
    tests++; if (bus.stall !== 1'b1) begin $display("FAIL lh_split_stall got=%b exp=1", bus.stall); fails++; end
    next_cycle();
    @(negedge clk);
    tests++; if (bus.rdata !== 32'h0000_5544) begin $display("FAIL lh_split_rdata got=%h exp=00005544", bus.rdata); fails++; end
    next_cycle();
  endtask

  task automatic test_straddle_store();
    mem[4] <= 32'h0;
    mem[5] <= 32'h0;
    drive(1'b1, 1'b1, F3_W, 32'h12, 32'hDEAD_BEEF);
    @(negedge clk);
    tests++; if (bus.stall !== 1'b1 || mem_we !== 1'b1) begin $display("FAIL sw_split_c1 stall=%b we=%b exp=1/1", bus.stall, mem_we); fails++; end
    next_cycle();
    @(negedge clk);
    tests++; if (bus.stall !== 1'b0 || mem_we !== 1'b1) begin $display("FAIL sw_split_c2 stall=%b we=%b exp=0/1", bus.stall, mem_we); fails++; end
    next_cycle();
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    tests++; if (mem[4] !== 32'hBEEF_0000) begin $display("FAIL sw_split_lo got=%h exp=beef0000", mem[4]); fails++; end
    tests++; if (mem[5] !== 32'h0000_DEAD) begin $display("FAIL sw_split_hi got=%h exp=0000dead", mem[5]); fails++; end
    next_cycle();
  endtask

  task automatic test_faults();
    logic [2:0]  f3   [5] = '{F3_W, 3'b011, F3_W, F3_W, 3'b100};
    logic [31:0] addr [5] = '{32'h1000, 32'h10, 32'hFFD, 32'h1000, 32'h20};
    logic        wr   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, wr[i], f3[i], addr[i], 32'hFFFF_FFFF);
      @(negedge clk);
      tests++;
      if (bus.fault !== 1'b1 || mem_we !== 1'b0 || bus.stall !== 1'b0 || bus.rdata !== 32'h0) begin
        $display("FAIL fault_case%0d fault=%b we=%b stall=%b rdata=%h exp=1/0/0/0",
                 i, bus.fault, mem_we, bus.stall, bus.rdata);
        fails++;
      end
      next_cycle();
    end
    drive(1'b1, 1'b0, F3_W, 32'h14, 32'h0);
    @(negedge clk);
    tests++; if (bus.fault !== 1'b0 || bus.stall !== 1'b0) begin $display("FAIL fault_recover fault=%b stall=%b exp=0/0", bus.fault, bus.stall); fails++; end
    next_cycle();
  endtask

  task automatic test_flush();
    mem[12] <= 32'h0102_0304;
    mem[13] <= 32'h0506_0708;
    drive(1'b1, 1'b1, F3_H, 32'h33, 32'h0000_AAAA);
    @(negedge clk);
    tests++; if (bus.stall !== 1'b1) begin $display("FAIL flush_stall got=%b exp=1", bus.stall); fails++; end
    next_cycle();
    bus.req = 1'b0;
    @(negedge clk);
    tests++; if (mem_we !== 1'b0) begin $display("FAIL flush_we got=%b exp=0", mem_we); fails++; end
    next_cycle();
    tests++; if (mem[12] !== 32'hAA02_0304) begin $display("FAIL flush_lo got=%h exp=aa020304", mem[12]); fails++; end
    tests++; if (mem[13] !== 32'h0506_0708) begin $display("FAIL flush_hi got=%h exp=05060708", mem[13]); fails++; end
    drive(1'b1, 1'b0, F3_BU, 32'h34, 32'h0);
    @(negedge clk);
    tests++; if (bus.stall !== 1'b0 || bus.rdata !== 32'h0000_0008) begin $display("FAIL flush_after stall=%b rdata=%h exp=0/00000008", bus.stall, bus.rdata); fails++; end
    next_cycle();
  endtask

  task automatic test_reset_in_second();
    mem[8] <= 32'h1234_5678;
    mem[9] <= 32'hCAFE_BABE;
    drive(1'b1, 1'b1, F3_W, 32'h21, 32'hA1B2_C3D4);
    @(negedge clk);
    tests++; if (bus.stall !== 1'b1 || mem_we !== 1'b1) begin $display("FAIL rst2_c1 stall=%b we=%b exp=1/1", bus.stall, mem_we); fails++; end
    next_cycle();
    tests++; if (mem_addr !== 10'd9) begin $display("FAIL rst2_second_addr got=%0d exp=9", mem_addr); fails++; end
    #1 rst = 1'b0;
    #1;
    tests++; if (mem_we !== 1'b0 || bus.stall !== 1'b0 || mem_addr !== '0) begin $display("FAIL rst2_in_reset we=%b stall=%b addr=%0d exp=0/0/0", mem_we, bus.stall, mem_addr); fails++; end
    next_cycle();
    tests++; if (mem[8] !== 32'hB2C3_D478) begin $display("FAIL rst2_lo_kept got=%h exp=b2c3d478", mem[8]); fails++; end
    tests++; if (mem[9] !== 32'hCAFE_BABE) begin $display("FAIL rst2_hi_untouched got=%h exp=cafebabe", mem[9]); fails++; end
    rst = 1'b1;
    drive(1'b1, 1'b0, F3_W, 32'h24, 32'h0);
    @(negedge clk);
    tests++; if (bus.stall !== 1'b0 || bus.rdata !== 32'hCAFE_BABE) begin $display("FAIL rst2_next_lw stall=%b rdata=%h exp=0/cafebabe", bus.stall, bus.rdata); fails++; end
    next_cycle();
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'h0;
    test_reset();
    test_subword_load();
    test_byte_store();
    test_straddle_load();
    test_straddle_store();
    test_faults();
    test_flush();
    test_reset_in_second();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
